instruction_fetch_unit: RTL and testbench

Front-end fetch stage of the RV32IM pipeline, directly upstream of `instruction_cache`. Owns the program counter and drives the cache `ADDRESS` port, then accepts `READDATA` whenever cache `BUSYWAIT` is low. Accepted words go into a small in-order buffer that presents `{PC, instruction}` to the IF/ID register. Handles decode back-pressure and branch/jump redirects, including redirects that arrive while a cache miss is outstanding.

---
 rtl/instruction_fetch_unit.sv | 152 +++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// RV32IM fetch stage: owns the PC, drives the instruction cache address port and
// queues returned words in a small in-order buffer feeding the IF/ID register.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] IC_ADDRESS,
  input  logic [31:0] IC_READDATA,
  input  logic        IC_BUSYWAIT,
  input  logic        ID_STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic [31:0] IF_INSTR,
  output logic [31:0] IF_PC,
  output logic        IF_VALID
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

  typedef enum logic {
    S_FETCH   = 1'b0,
    S_DISCARD = 1'b1
  } state_e;

  state_e             r_state;
  logic [31:0]        r_pc;
  logic [31:0]        r_pending_pc;
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;
  logic [31:0]        r_buf_pc    [BUF_DEPTH];
  logic [31:0]        r_buf_instr [BUF_DEPTH];

  state_e             w_state_nxt;
  logic [31:0]        w_pc_nxt;
  logic [31:0]        w_pending_nxt;
  logic [PTR_W-1:0]   w_head_nxt;
  logic [PTR_W-1:0]   w_tail_nxt;
  logic [CNT_W-1:0]   w_count_nxt;
  logic               w_wr_en;
  logic               w_accept;
  logic               w_pop;
  logic               w_full;
  logic [31:0]        w_target;
  logic               w_unused_tgt_lsbs;

  assign w_target          = {BRANCH_TARGET[31:2], 2'b00};
  assign w_unused_tgt_lsbs = ^BRANCH_TARGET[1:0];
  assign w_full            = (r_count == FULL_CNT);
  assign w_pop             = IF_VALID && !ID_STALL;

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_pending_nxt = r_pending_pc;
    w_head_nxt    = r_head;
    w_tail_nxt    = r_tail;
    w_count_nxt   = r_count;
    w_wr_en       = 1'b0;
    w_accept      = 1'b0;

    case (r_state)
      S_FETCH: begin
        if (BRANCH_TAKEN) begin
          w_head_nxt  = r_tail;
          w_count_nxt = '0;
          if (!IC_BUSYWAIT) begin
            w_pc_nxt = w_target;
          end else begin
            // Hold the PC so the outstanding miss completes on a stable address.
            w_pending_nxt = w_target;
            w_state_nxt   = S_DISCARD;
          end
        end else begin
          w_accept = !IC_BUSYWAIT && (!w_full || w_pop);
          if (w_accept) begin
            w_wr_en    = 1'b1;
            w_tail_nxt = r_tail + PTR_W'(1);
            w_pc_nxt   = r_pc + 32'd4;
          end
          if (w_pop) begin
            w_head_nxt = r_head + PTR_W'(1);
          end
          case ({w_accept, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
          endcase
        end
      end

      S_DISCARD: begin
        if (BRANCH_TAKEN) begin
          w_head_nxt    = r_tail;
          w_count_nxt   = '0;
          w_pending_nxt = w_target;
        end else if (w_pop) begin
          w_head_nxt  = r_head + PTR_W'(1);
          w_count_nxt = r_count - CNT_W'(1);
        end
        // The returning word belongs to the abandoned path and is dropped.
        if (!IC_BUSYWAIT) begin
          w_pc_nxt    = BRANCH_TAKEN ? w_target : r_pending_pc;
          w_state_nxt = S_FETCH;
        end
      end

      default: w_state_nxt = S_FETCH;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_pending_pc <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_pending_pc <= w_pending_nxt;
      r_head       <= w_head_nxt;
      r_tail       <= w_tail_nxt;
      r_count      <= w_count_nxt;
    end
  end

  // NOTE: buffer storage has no reset; an entry is only observable once count
  // covers it, and the empty head is masked to zero below.
  always_ff @(posedge CLK) begin
    if (w_wr_en) begin
      r_buf_pc[r_tail]    <= r_pc;
      r_buf_instr[r_tail] <= IC_READDATA;
    end
  end

  assign IC_ADDRESS = r_pc;
  assign IF_VALID   = (r_count != '0);
  assign IF_INSTR   = IF_VALID ? r_buf_instr[r_head] : 32'h0;
  assign IF_PC      = IF_VALID ? r_buf_pc[r_head]    : 32'h0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: straight-line fetch, decode stall,
// miss, redirects on hit and during miss, PC wrap and reset while discarding.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (RESET_PC = 0)
  logic        rst_n, busy, stall, br;
  logic [31:0] br_tgt;
  logic [31:0] ic_addr, ic_rdata, if_instr, if_pc;
  logic        if_valid;

  // Wrap DUT (RESET_PC = 0xFFFFFFFC), always hitting, never stalled
  logic        w_rst_n;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc;
  logic        w_valid;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0013;
  endfunction

  // Cache model: correct word on a hit, junk while busy.
  assign ic_rdata = busy ? 32'hDEAD_BEEF : mem_word(ic_addr);
  assign w_rdata  = mem_word(w_addr);

  instruction_fetch_unit #(.RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
    .CLK(clk), .RESET(rst_n), .IC_ADDRESS(ic_addr), .IC_READDATA(ic_rdata),
    .IC_BUSYWAIT(busy), .ID_STALL(stall), .BRANCH_TAKEN(br), .BRANCH_TARGET(br_tgt),
    .IF_INSTR(if_instr), .IF_PC(if_pc), .IF_VALID(if_valid)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(2)) dut_wrap (
    .CLK(clk), .RESET(w_rst_n), .IC_ADDRESS(w_addr), .IC_READDATA(w_rdata),
    .IC_BUSYWAIT(1'b0), .ID_STALL(1'b0), .BRANCH_TAKEN(1'b0), .BRANCH_TARGET(32'h0),
    .IF_INSTR(w_instr), .IF_PC(w_pc), .IF_VALID(w_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks all main-DUT outputs; an empty buffer must present zeros.
  task automatic expect_out(input string tag, input logic [31:0] addr,
                            input logic valid, input logic [31:0] pc);
    check({tag, ".addr"},  ic_addr, addr);
    check({tag, ".valid"}, {31'b0, if_valid}, {31'b0, valid});
    check({tag, ".pc"},    if_pc, valid ? pc : 32'h0);
    check({tag, ".instr"}, if_instr, valid ? mem_word(pc) : 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    expect_out("rst", 32'h0, 1'b0, 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; busy = 1'b0; stall = 1'b0; br = 1'b0; br_tgt = 32'h0;
    w_rst_n = 1'b0;

    // Reset and straight-line fetch
    tick(); tick();
    expect_out("reset", 32'h0, 1'b0, 32'h0);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      expect_out("line", 32'(4 * i), 1'b1, 32'(4 * (i - 1)));
    end

    // Decode stall: buffer fills, address freezes at 8, head held at 0
    do_reset();
    stall = 1'b1;
    tick(); expect_out("stall1", 32'h4, 1'b1, 32'h0);
    tick(); expect_out("stall2", 32'h8, 1'b1, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick(); expect_out("stall_full", 32'h8, 1'b1, 32'h0);
    end
    stall = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick(); expect_out("unstall", 32'(8 + 4 * i), 1'b1, 32'(4 * i));
    end

    // Miss at 0x20 for 10 cycles
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    expect_out("pre_miss", 32'h20, 1'b1, 32'h1C);
    busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(); expect_out("miss", 32'h20, 1'b0, 32'h0);
    end
    busy = 1'b0;
    tick(); expect_out("miss_done", 32'h24, 1'b1, 32'h20);

    // Redirect on hit with a full buffer at 0x10
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    expect_out("pre_br", 32'hC, 1'b1, 32'h8);
    stall = 1'b1;
    tick(); expect_out("br_full", 32'h10, 1'b1, 32'h8);
    br = 1'b1; br_tgt = 32'h103;
    tick(); expect_out("br_hit", 32'h100, 1'b0, 32'h0);
    br = 1'b0; stall = 1'b0;
    tick(); expect_out("br_tgt", 32'h104, 1'b1, 32'h100);

    // Two redirects during a miss at 0x40
    do_reset();
    for (int i = 0; i < 16; i++) tick();
    expect_out("pre_dmiss", 32'h40, 1'b1, 32'h3C);
    busy = 1'b1;
    tick(); expect_out("dmiss", 32'h40, 1'b0, 32'h0);
    br = 1'b1; br_tgt = 32'h200;
    tick(); expect_out("disc1", 32'h40, 1'b0, 32'h0);
    br = 1'b0;
    tick(); expect_out("disc2", 32'h40, 1'b0, 32'h0);
    br = 1'b1; br_tgt = 32'h300;
    tick(); expect_out("disc3", 32'h40, 1'b0, 32'h0);
    br = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(); expect_out("disc_hold", 32'h40, 1'b0, 32'h0);
    end
    busy = 1'b0;
    tick(); expect_out("disc_drop", 32'h300, 1'b0, 32'h0);
    tick(); expect_out("disc_tgt", 32'h304, 1'b1, 32'h300);

    // Reset while in DISCARD must come back in FETCH at RESET_PC
    busy = 1'b1; br = 1'b1; br_tgt = 32'h500;
    tick(); expect_out("to_disc", 32'h304, 1'b0, 32'h0);
    br = 1'b0; rst_n = 1'b0;
    tick(); expect_out("disc_rst", 32'h0, 1'b0, 32'h0);
    rst_n = 1'b1; busy = 1'b0;
    tick(); expect_out("post_rst", 32'h4, 1'b1, 32'h0);

    // PC wrap from 0xFFFFFFFC
    check("wrap.rst_addr", w_addr, 32'hFFFF_FFFC);
    check("wrap.rst_valid", {31'b0, w_valid}, 32'h0);
    w_rst_n = 1'b1;
    tick();
    check("wrap.addr0", w_addr, 32'h0);
    check("wrap.pc0", w_pc, 32'hFFFF_FFFC);
    check("wrap.instr0", w_instr, mem_word(32'hFFFF_FFFC));
    tick();
    check("wrap.addr1", w_addr, 32'h4);
    check("wrap.pc1", w_pc, 32'h0);
    check("wrap.valid1", {31'b0, w_valid}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
